// File: rtl/irq_pending_ctrl_pkg.sv
// Shared types and helpers for the interrupt pending controller.
// Holds the claim FSM encoding and the bit-width helper used for irq_id sizing.
package irq_pending_ctrl_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'b00,
        IRQ_REQ  = 2'b01,
        IRQ_HOLD = 2'b10,
        IRQ_BAD  = 2'b11
    } irq_state_e;

    // Number of bits needed to represent value; never less than 1.
    function automatic int clogb2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 0) begin
                bits = i + 1;
            end
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/irq_pending_ctrl_priority_encoder.sv
// Highest-index-wins priority encoder over the masked pending vector.
// Emits the winning index, its one-hot select and an any-set flag.
module priority_encoder
    import irq_pending_ctrl_pkg::*;
#(
    parameter int INPUT_WIDTH = 16,
    parameter int OUT_W       = clogb2(INPUT_WIDTH - 1)
) (
    input  logic [INPUT_WIDTH-1:0] a_i,
    output logic [INPUT_WIDTH-1:0] seln_o,
    output logic [OUT_W-1:0]       b_o,
    output logic                   any_o
);

    always_comb begin
        seln_o = '0;
        b_o    = '0;
        any_o  = 1'b0;
        // Ascending scan so the highest set index is the last to write.
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            if (a_i[i]) begin
                seln_o    = '0;
                seln_o[i] = 1'b1;
                b_o       = OUT_W'(i);
                any_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt front end: synchronises raw lines, latches pending, masks them
// and hands the highest-priority source to the CPU over a req/ack claim.
//
// state    | meaning
// IRQ_IDLE | no claim outstanding; issue one when any masked pending bit is set
// IRQ_REQ  | claim presented, irq_id frozen until irq_ack
// IRQ_HOLD | one settle cycle after ack so the cleared pending reaches the encoder
// IRQ_BAD  | unreachable; recovers to IRQ_IDLE
module irq_pending_ctrl
    import irq_pending_ctrl_pkg::*;
#(
    parameter int               N_IRQ       = 16,
    parameter int               ID_W        = clogb2(N_IRQ - 1),
    parameter int               SYNC_STAGES = 2,
    parameter logic [N_IRQ-1:0] EDGE_MASK   = {N_IRQ{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    output logic [N_IRQ-1:0] mask,
    output logic [N_IRQ-1:0] pending,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    input  logic             irq_ack
);

    logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [N_IRQ-1:0] s_d_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q;
    logic [N_IRQ-1:0] sel_q;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] masked;
    logic [N_IRQ-1:0] enc_seln;
    logic [ID_W-1:0]  enc_b;
    logic             enc_any;
    logic [ID_W-1:0]  id_q;
    logic             req_q;
    logic             ack_acc;
    irq_state_e       state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            s_d_q <= '0;
        end else begin
            sync_q[0] <= irq_src;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign ack_acc = (state_q == IRQ_REQ) && irq_ack;
    assign clr     = ack_acc ? sel_q : '0;

    // A fresh edge is ORed in after the clear, so an edge in the ack cycle survives.
    always_comb begin
        pending_d = (EDGE_MASK &
                     ((pending_q & ~clr) | (sync_q[SYNC_STAGES-1] & ~s_d_q)))
                  | (~EDGE_MASK & sync_q[SYNC_STAGES-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            pending_q <= pending_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    assign masked = pending_q & mask_q;

    priority_encoder #(
        .INPUT_WIDTH (N_IRQ),
        .OUT_W       (ID_W)
    ) u_prio (
        .a_i    (masked),
        .seln_o (enc_seln),
        .b_o    (enc_b),
        .any_o  (enc_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IRQ_IDLE;
            req_q   <= 1'b0;
            id_q    <= '0;
            sel_q   <= '0;
        end else begin
            case (state_q)
                IRQ_IDLE: begin
                    if (enc_any) begin
                        id_q    <= enc_b;
                        sel_q   <= enc_seln;
                        req_q   <= 1'b1;
                        state_q <= IRQ_REQ;
                    end
                end
                IRQ_REQ: begin
                    if (irq_ack) begin
                        req_q   <= 1'b0;
                        state_q <= IRQ_HOLD;
                    end
                end
                IRQ_HOLD: begin
                    state_q <= IRQ_IDLE;
                end
                IRQ_BAD: begin
                    req_q   <= 1'b0;
                    state_q <= IRQ_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IRQ_IDLE;
                end
            endcase
        end
    end

    assign mask    = mask_q;
    assign pending = pending_q;
    assign irq_req = req_q;
    assign irq_id  = id_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: latency, priority, masking, races and level re-claim.
module tb_irq_pending_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] irq_src;
    logic        mask_we;
    logic [15:0] mask_wdata;
    logic [15:0] mask;
    logic [15:0] pending;
    logic        irq_req;
    logic [3:0]  irq_id;
    logic        irq_ack;

    int tests_run;
    int tests_failed;

    irq_pending_ctrl #(
        .N_IRQ       (16),
        .SYNC_STAGES (2),
        .EDGE_MASK   (16'hFFFB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_src    (irq_src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .pending    (pending),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        irq_src = '0;
        mask_we = 1'b0;
        irq_ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic write_mask(input logic [15:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic pulse_src(input int idx);
        irq_src[idx] = 1'b1;
        tick();
        irq_src[idx] = 1'b0;
    endtask

    task automatic test_reset();
        bit seen_req;
        rst_n   = 1'b0;
        irq_src = 16'hFFFF;
        tick(); tick(); tick();
        tests_run++;
        if ({mask, pending, irq_req, irq_id} !== 37'd0) begin
            tests_failed++;
            $display("FAIL reset_vals: got mask=%h pend=%h req=%b id=%h want all 0", mask, pending, irq_req, irq_id);
        end
        rst_n = 1'b1;
        tick(); tick();
        tests_run++;
        if (pending !== 16'h0000 || irq_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: got pend=%h req=%b want 0000/0", pending, irq_req);
        end
        tick();
        tests_run++;
        if (pending !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL reset_pend_fill: got %h want FFFF", pending);
        end
        seen_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (irq_req) seen_req = 1'b1;
        end
        tests_run++;
        if (seen_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_masked_noreq: got req seen=%b want 0", seen_req);
        end
    endtask

    task automatic test_single_edge();
        bit seen_req;
        do_reset();
        write_mask(16'hFFFF);
        tests_run++;
        if (mask !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL se_mask: got %h want FFFF", mask);
        end
        pulse_src(5);
        tick();
        tick();
        tests_run++;
        if (pending !== 16'h0020 || irq_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL se_pend: got pend=%h req=%b want 0020/0", pending, irq_req);
        end
        tick();
        tests_run++;
        if (irq_req !== 1'b1 || irq_id !== 4'd5) begin
            tests_failed++;
            $display("FAIL se_claim: got req=%b id=%0d want 1/5", irq_req, irq_id);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tests_run++;
        if (irq_req !== 1'b0 || pending !== 16'h0000) begin
            tests_failed++;
            $display("FAIL se_ack: got req=%b pend=%h want 0/0000", irq_req, pending);
        end
        seen_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (irq_req) seen_req = 1'b1;
        end
        tests_run++;
        if (seen_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL se_no_second: got req seen=%b want 0", seen_req);
        end
    endtask

    task automatic test_priority();
        do_reset();
        write_mask(16'hFFFF);
        irq_src = 16'h1008;
        tick();
        irq_src = '0;
        tick(); tick(); tick();
        tests_run++;
        if (irq_req !== 1'b1 || irq_id !== 4'd12 || pending !== 16'h1008) begin
            tests_failed++;
            $display("FAIL prio_first: got req=%b id=%0d pend=%h want 1/12/1008", irq_req, irq_id, pending);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tests_run++;
        if (irq_req !== 1'b0 || pending !== 16'h0008) begin
            tests_failed++;
            $display("FAIL prio_ack: got req=%b pend=%h want 0/0008", irq_req, pending);
        end
        tick();
        tests_run++;
        if (irq_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_gap: got req=%b want 0", irq_req);
        end
        tick();
        tests_run++;
        if (irq_req !== 1'b1 || irq_id !== 4'd3) begin
            tests_failed++;
            $display("FAIL prio_second: got req=%b id=%0d want 1/3", irq_req, irq_id);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tests_run++;
        if (pending !== 16'h0000) begin
            tests_failed++;
            $display("FAIL prio_clear: got pend=%h want 0000", pending);
        end
        tick(); tick();
    endtask

    task automatic test_mask();
        do_reset();
        pulse_src(7);
        tick(); tick(); tick(); tick();
        tests_run++;
        if (pending !== 16'h0080 || irq_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL mask_accum: got pend=%h req=%b want 0080/0", pending, irq_req);
        end
        irq_ack = 1'b1;
        tick(); tick();
        irq_ack = 1'b0;
        tests_run++;
        if (pending !== 16'h0080) begin
            tests_failed++;
            $display("FAIL mask_idle_ack: got pend=%h want 0080", pending);
        end
        write_mask(16'h0080);
        tests_run++;
        if (mask !== 16'h0080 || irq_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL mask_write: got mask=%h req=%b want 0080/0", mask, irq_req);
        end
        tick();
        tests_run++;
        if (irq_req !== 1'b1 || irq_id !== 4'd7) begin
            tests_failed++;
            $display("FAIL mask_unmask_claim: got req=%b id=%0d want 1/7", irq_req, irq_id);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tick(); tick();
    endtask

    task automatic test_race_edge();
        do_reset();
        write_mask(16'hFFFF);
        pulse_src(9);
        tick(); tick(); tick();
        tests_run++;
        if (irq_req !== 1'b1 || irq_id !== 4'd9) begin
            tests_failed++;
            $display("FAIL race_edge_claim: got req=%b id=%0d want 1/9", irq_req, irq_id);
        end
        pulse_src(9);
        tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tests_run++;
        if (irq_req !== 1'b0 || pending !== 16'h0200) begin
            tests_failed++;
            $display("FAIL race_edge_kept: got req=%b pend=%h want 0/0200", irq_req, pending);
        end
        tick(); tick();
        tests_run++;
        if (irq_req !== 1'b1 || irq_id !== 4'd9) begin
            tests_failed++;
            $display("FAIL race_edge_reclaim: got req=%b id=%0d want 1/9", irq_req, irq_id);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tests_run++;
        if (pending !== 16'h0000) begin
            tests_failed++;
            $display("FAIL race_edge_final: got pend=%h want 0000", pending);
        end
        tick(); tick();
    endtask

    task automatic test_race_mask();
        do_reset();
        write_mask(16'hFFFF);
        pulse_src(11);
        tick(); tick(); tick();
        write_mask(16'h0000);
        tick(); tick(); tick();
        tests_run++;
        if (irq_req !== 1'b1 || irq_id !== 4'd11 || mask !== 16'h0000) begin
            tests_failed++;
            $display("FAIL race_mask_hold: got req=%b id=%0d mask=%h want 1/11/0000", irq_req, irq_id, mask);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tests_run++;
        if (irq_req !== 1'b0 || pending !== 16'h0000) begin
            tests_failed++;
            $display("FAIL race_mask_ack: got req=%b pend=%h want 0/0000", irq_req, pending);
        end
        tick(); tick();
    endtask

    task automatic test_race_reset();
        do_reset();
        write_mask(16'hFFFF);
        pulse_src(13);
        tick(); tick(); tick();
        tests_run++;
        if (irq_req !== 1'b1 || irq_id !== 4'd13) begin
            tests_failed++;
            $display("FAIL race_rst_claim: got req=%b id=%0d want 1/13", irq_req, irq_id);
        end
        rst_n   = 1'b0;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tests_run++;
        if (irq_req !== 1'b0 || pending !== 16'h0000 || mask !== 16'h0000 || irq_id !== 4'd0) begin
            tests_failed++;
            $display("FAIL race_rst_clear: got req=%b pend=%h mask=%h id=%0d want 0/0000/0000/0", irq_req, pending, mask, irq_id);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_level();
        int bad;
        do_reset();
        write_mask(16'hFFFF);
        irq_src[2] = 1'b1;
        tick(); tick(); tick(); tick();
        tests_run++;
        if (irq_req !== 1'b1 || irq_id !== 4'd2) begin
            tests_failed++;
            $display("FAIL level_claim: got req=%b id=%0d want 1/2", irq_req, irq_id);
        end
        bad = 0;
        for (int r = 0; r < 3; r++) begin
            irq_ack = 1'b1;
            tick();
            irq_ack = 1'b0;
            if (irq_req !== 1'b0 || pending !== 16'h0004) bad++;
            tick(); tick();
            if (irq_req !== 1'b1 || irq_id !== 4'd2) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL level_reclaim: got %0d bad samples want 0", bad);
        end
        irq_src[2] = 1'b0;
        tick(); tick(); tick();
        tests_run++;
        if (pending !== 16'h0000 || irq_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL level_quiet: got pend=%h req=%b want 0000/1", pending, irq_req);
        end
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tick(); tick(); tick();
        tests_run++;
        if (irq_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL level_done: got req=%b want 0", irq_req);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n      = 1'b0;
        irq_src    = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        irq_ack    = 1'b0;
        #1;
        test_reset();
        test_single_edge();
        test_priority();
        test_mask();
        test_race_edge();
        test_race_mask();
        test_race_reset();
        test_level();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
